// File: rtl/writeback_regfile_if.sv
// Writeback-stage bus for the register file: WB-stage data/control in,
// read-port addresses in, read data and writeback status out.
interface writeback_regfile_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] in_ALUResult;
    logic [DATA_W-1:0] in_MemoryData;
    logic [DATA_W-1:0] in_PCOrBranch;
    logic [4:0]        in_WriteRegister;
    logic              in_CtrlRegWrite;
    logic              in_CtrlALUOrMem;
    logic              in_CtrlALUMemOrPC;
    logic              in_CtrlRegisterOrPC;
    logic [4:0]        in_ReadReg1;
    logic [4:0]        in_ReadReg2;
    logic [DATA_W-1:0] out_ReadData1;
    logic [DATA_W-1:0] out_ReadData2;
    logic [DATA_W-1:0] out_WBData;
    logic [4:0]        out_WBRegister;
    logic              out_WBValid;
    logic [15:0]       out_WriteCount;

    modport master (
        output in_ALUResult, in_MemoryData, in_PCOrBranch, in_WriteRegister,
               in_CtrlRegWrite, in_CtrlALUOrMem, in_CtrlALUMemOrPC,
               in_CtrlRegisterOrPC, in_ReadReg1, in_ReadReg2,
        input  out_ReadData1, out_ReadData2, out_WBData, out_WBRegister,
               out_WBValid, out_WriteCount
    );

    modport slave (
        input  in_ALUResult, in_MemoryData, in_PCOrBranch, in_WriteRegister,
               in_CtrlRegWrite, in_CtrlALUOrMem, in_CtrlALUMemOrPC,
               in_CtrlRegisterOrPC, in_ReadReg1, in_ReadReg2,
        output out_ReadData1, out_ReadData2, out_WBData, out_WBRegister,
               out_WBValid, out_WriteCount
    );
endinterface

// File: rtl/writeback_regfile.sv
// 32-entry register file with writeback mux, write-through read bypass,
// registered writeback status and a wrapping commit counter.
module writeback_regfile #(
    parameter int                DATA_W  = 32,
    parameter logic [DATA_W-1:0] SP_INIT = 32'h7FFF_EFFC
) (
    input logic                clk,
    input logic                reset,
    writeback_regfile_if.slave bus
);
    logic [DATA_W-1:0] regs_reg [32];
    logic [DATA_W-1:0] wb_data_reg;
    logic [4:0]        wb_register_reg;
    logic              wb_valid_reg;
    logic [15:0]       write_count_reg;

    logic [DATA_W-1:0] wr_data_next;
    logic [4:0]        wr_dest_next;
    logic              commit_next;

    logic [4:0]        rd_addr [2];
    logic [DATA_W-1:0] rd_data [2];

    always_comb begin
        wr_data_next = bus.in_ALUResult;
        if (bus.in_CtrlALUMemOrPC) begin
            wr_data_next = bus.in_PCOrBranch;
        end else if (bus.in_CtrlALUOrMem) begin
            wr_data_next = bus.in_MemoryData;
        end
        wr_dest_next = bus.in_CtrlRegisterOrPC ? 5'd31 : bus.in_WriteRegister;
        // Reset masks the commit so it also suppresses the read bypass.
        commit_next  = bus.in_CtrlRegWrite && !reset && (wr_dest_next != 5'd0);
    end

    assign rd_addr[0] = bus.in_ReadReg1;
    assign rd_addr[1] = bus.in_ReadReg2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_read_port
            always_comb begin
                rd_data[gi] = regs_reg[rd_addr[gi]];
                if (rd_addr[gi] == 5'd0) begin
                    rd_data[gi] = '0;
                end else if (commit_next && (rd_addr[gi] == wr_dest_next)) begin
                    rd_data[gi] = wr_data_next;
                end
            end
        end
    endgenerate

    assign bus.out_ReadData1 = rd_data[0];
    assign bus.out_ReadData2 = rd_data[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_reg[i] <= (i == 29) ? SP_INIT : '0;
            end
        end else if (commit_next) begin
            regs_reg[wr_dest_next] <= wr_data_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_data_reg     <= '0;
            wb_register_reg <= '0;
            wb_valid_reg    <= 1'b0;
            write_count_reg <= '0;
        end else begin
            wb_valid_reg <= commit_next;
            if (commit_next) begin
                wb_data_reg     <= wr_data_next;
                wb_register_reg <= wr_dest_next;
                write_count_reg <= write_count_reg + 16'd1;
            end
        end
    end

    assign bus.out_WBData     = wb_data_reg;
    assign bus.out_WBRegister = wb_register_reg;
    assign bus.out_WBValid    = wb_valid_reg;
    assign bus.out_WriteCount = write_count_reg;
endmodule

// File: tb/tb_writeback_regfile.sv
// Scoreboard bench for writeback_regfile: directed writes push expected
// writeback records; a monitor pops them whenever out_WBValid is seen.
module tb_writeback_regfile;
    typedef struct {
        logic [31:0] data;
        logic [4:0]  dest;
        logic [15:0] count;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic [15:0] exp_count;
    logic verbose;
    exp_t sb[$];

    writeback_regfile_if #(.DATA_W(32)) bus ();

    writeback_regfile #(
        .DATA_W (32),
        .SP_INIT(32'h7FFF_EFFC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Sets up one WB-stage transaction; the commit happens at the next edge.
    task automatic drive(input logic [31:0] alu, input logic [31:0] mem,
                         input logic [31:0] pcv, input logic [4:0] wr,
                         input logic we, input logic sel_mem,
                         input logic sel_link, input logic force31);
        logic [31:0] d;
        logic [4:0]  dst;
        exp_t        e;
        bus.in_ALUResult        = alu;
        bus.in_MemoryData       = mem;
        bus.in_PCOrBranch       = pcv;
        bus.in_WriteRegister    = wr;
        bus.in_CtrlRegWrite     = we;
        bus.in_CtrlALUOrMem     = sel_mem;
        bus.in_CtrlALUMemOrPC   = sel_link;
        bus.in_CtrlRegisterOrPC = force31;
        d   = sel_link ? pcv : (sel_mem ? mem : alu);
        dst = force31 ? 5'd31 : wr;
        if (we && !reset && dst != 5'd0) begin
            exp_count = exp_count + 16'd1;
            e.data  = d;
            e.dest  = dst;
            e.count = exp_count;
            sb.push_back(e);
        end
        if (verbose)
            $display("txn: we=%0b dest=%0d data=%h reset=%0b", we, dst, d, reset);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        bus.in_CtrlRegWrite = 1'b0;
    endtask

    // Monitor: compares registered writeback status against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.out_WBValid === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wb_spurious: got valid with reg %0d data %h, expected no commit",
                             bus.out_WBRegister, bus.out_WBData);
                end else begin
                    e = sb.pop_front();
                    check("wb_data", bus.out_WBData, e.data);
                    check("wb_reg", {27'd0, bus.out_WBRegister}, {27'd0, e.dest});
                    check("wb_count", {16'd0, bus.out_WriteCount}, {16'd0, e.count});
                end
            end
        end
    end

    initial begin
        int n;
        checks    = 0;
        errors    = 0;
        exp_count = 16'd0;
        verbose   = 1'b1;
        reset     = 1'b1;
        bus.in_ReadReg1 = 5'd29;
        bus.in_ReadReg2 = 5'd5;
        drive(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();

        // Reset values
        check("rst_sp", bus.out_ReadData1, 32'h7FFF_EFFC);
        check("rst_r5", bus.out_ReadData2, 32'h0);
        check("rst_count", {16'd0, bus.out_WriteCount}, 32'h0);
        check("rst_valid", {31'd0, bus.out_WBValid}, 32'h0);
        check("rst_wbdata", bus.out_WBData, 32'h0);
        reset = 1'b0;

        // ALU write to reg 8 with same-cycle read bypass on both ports
        bus.in_ReadReg1 = 5'd8;
        bus.in_ReadReg2 = 5'd8;
        drive(32'h1234_5678, 32'h1111_1111, 32'h2222_2222, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        check("bypass_r8_p1", bus.out_ReadData1, 32'h1234_5678);
        check("bypass_r8_p2", bus.out_ReadData2, 32'h1234_5678);
        tick();
        check("stored_r8", bus.out_ReadData1, 32'h1234_5678);

        // Link write forced to reg 31; reg 3 must keep its earlier value
        drive(32'h0000_0033, 32'h0, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(32'h5555_0000, 32'h6666_0000, 32'h0040_0024, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        bus.in_ReadReg1 = 5'd31;
        bus.in_ReadReg2 = 5'd3;
        #1;
        check("link_r31", bus.out_ReadData1, 32'h0040_0024);
        check("link_r3_kept", bus.out_ReadData2, 32'h0000_0033);

        // Link select beats memory select
        drive(32'h0000_CCCC, 32'h0000_BBBB, 32'hAAAA_0000, 5'd10, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        drive(32'h0000_CCCC, 32'h0000_BBBB, 32'hAAAA_0000, 5'd11, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        bus.in_ReadReg1 = 5'd10;
        bus.in_ReadReg2 = 5'd11;
        #1;
        check("prio_link_r10", bus.out_ReadData1, 32'hAAAA_0000);
        check("prio_mem_r11", bus.out_ReadData2, 32'h0000_BBBB);

        // Write to reg 0 is discarded: no bypass, no valid, no count
        bus.in_ReadReg1 = 5'd0;
        drive(32'hDEAD_BEEF, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        check("r0_no_bypass", bus.out_ReadData1, 32'h0);
        tick();
        @(negedge clk);
        check("r0_read", bus.out_ReadData1, 32'h0);
        check("r0_valid", {31'd0, bus.out_WBValid}, 32'h0);
        check("r0_count", {16'd0, bus.out_WriteCount}, {16'd0, exp_count});
        check("r0_wbdata_hold", bus.out_WBData, 32'h0000_BBBB);
        @(posedge clk);
        #1;

        // Reset dominates a simultaneous write to reg 9
        bus.in_ReadReg1 = 5'd9;
        drive(32'h0000_0055, 32'h0, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        reset = 1'b1;
        drive(32'h0000_0077, 32'h0, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        check("rst_no_bypass_r9", bus.out_ReadData1, 32'h0000_0055);
        tick();
        exp_count = 16'd0;
        check("rst_r9", bus.out_ReadData1, 32'h0);
        check("rst_count2", {16'd0, bus.out_WriteCount}, 32'h0);
        check("rst_valid2", {31'd0, bus.out_WBValid}, 32'h0);
        reset = 1'b0;
        drive(32'h0000_0099, 32'hCAFE_0001, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        check("mem_r9", bus.out_ReadData1, 32'hCAFE_0001);

        // Drive the counter to 16'hFFFF, then one more commit wraps it
        verbose = 1'b0;
        n = 0;
        while (exp_count != 16'hFFFF) begin
            drive(n, 32'h0, 32'h0, 5'((n % 31) + 1), 1'b1, 1'b0, 1'b0, 1'b0);
            tick();
            n++;
        end
        @(negedge clk);
        check("count_ffff", {16'd0, bus.out_WriteCount}, 32'h0000_FFFF);
        @(posedge clk);
        #1;
        verbose = 1'b1;
        drive(32'h0BAD_F00D, 32'h0, 32'h0, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        @(negedge clk);
        check("count_wrap", {16'd0, bus.out_WriteCount}, 32'h0);

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/writeback_regfile.md
WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

Interface
- REQ-001: Parameters SHALL be, one per line:
  - DATA_W, 32, datapath width.
  - SP_INIT, 32'h7FFF_EFFC, reset value of register 29 ($sp).
- REQ-002: Ports SHALL be, one per line:
  - clk, in, 1, single clock; all state updates on rising edge.
  - reset, in, 1, synchronous, active-high.
  - in_ALUResult, in, DATA_W, WB-stage ALU result.
  - in_MemoryData, in, DATA_W, WB-stage load data.
  - in_PCOrBranch, in, DATA_W, WB-stage link value (PC+4).
  - in_WriteRegister, in, 5, destination register from rd/rt mux.
  - in_CtrlRegWrite, in, 1, writeback enable.
  - in_CtrlALUOrMem, in, 1, 0 = ALU result, 1 = memory data.
  - in_CtrlALUMemOrPC, in, 1, 1 = link value overrides the ALU/Mem selection.
  - in_CtrlRegisterOrPC, in, 1, 1 = destination forced to register 31.
  - in_ReadReg1, in, 5, read port 1 address (rs).
  - in_ReadReg2, in, 5, read port 2 address (rt).
  - out_ReadData1, out, DATA_W, read port 1 data.
  - out_ReadData2, out, DATA_W, read port 2 data.
  - out_WBData, out, DATA_W, registered copy of the last committed write data.
  - out_WBRegister, out, 5, registered copy of the last committed destination.
  - out_WBValid, out, 1, registered: the previous cycle committed a write.
  - out_WriteCount, out, 16, number of committed writes.
- REQ-003: Reset SHALL be synchronous and active-high; there SHALL be exactly one clock, clk.

Function
- REQ-004: Storage SHALL be 32 registers of DATA_W bits.
- REQ-005: Register 0 SHALL read as 0 at all times and SHALL never be written.
- REQ-006: Write data SHALL be selected as follows:
  - in_CtrlALUMemOrPC=1: in_PCOrBranch.
  - Otherwise in_CtrlALUOrMem=1: in_MemoryData.
  - Otherwise: in_ALUResult.
- REQ-007: The write destination SHALL be 31 when in_CtrlRegisterOrPC=1, otherwise in_WriteRegister.
- REQ-008: A write SHALL commit on the rising edge when in_CtrlRegWrite=1, reset=0 and the destination is non-zero.
- REQ-009: Read ports SHALL be combinational from the addresses, with zero-cycle latency.
- REQ-010: Write-through bypass SHALL apply: when a commit is pending this cycle and the read address equals the destination (non-zero), that port SHALL return the write data in the same cycle.
- REQ-011: Both read ports MAY address the same register; each port SHALL independently apply REQ-005 and REQ-010.
- REQ-012: out_WBData/out_WBRegister/out_WBValid SHALL update on every edge to the write data, destination and commit flag (REQ-008) of that cycle; latency 1 cycle.
- REQ-013: When no commit occurs, out_WBValid SHALL be 0 and out_WBData/out_WBRegister SHALL hold their previous values.
- REQ-014: An attempted write to register 0 SHALL give out_WBValid=0 and SHALL NOT increment out_WriteCount.
- REQ-015: out_WriteCount SHALL increment by 1 per commit and SHALL wrap from 16'hFFFF to 0.
- REQ-016: Control inputs asserted simultaneously SHALL resolve by the priority in REQ-006 and REQ-007; the result SHALL be defined for every combination.

Reset
- REQ-017: Reset SHALL set the following on the rising edge with reset=1:
  - All registers to 0, except register 29 to SP_INIT.
  - out_WBData=0, out_WBRegister=0, out_WBValid=0, out_WriteCount=0.
- REQ-018: Reset SHALL dominate a simultaneous write; the write SHALL be discarded, with no commit and no count.
- REQ-019: During reset, read ports SHALL return pre-reset contents until the reset edge, and SHALL NOT apply bypass.
- REQ-020: The first edge with reset=0 SHALL process writes normally.

Verification
- REQ-021: Reset, then read reg 29 and reg 5 -> 32'h7FFF_EFFC and 0; out_WriteCount=0; out_WBValid=0.
- REQ-022: Write ALU 32'h1234_5678 to reg 8 while reading reg 8 in the same cycle -> read returns 32'h1234_5678 pre-edge (bypass); next cycle out_WBValid=1, out_WBRegister=8, out_WriteCount=1.
- REQ-023: CtrlALUMemOrPC=1, CtrlRegisterOrPC=1, in_PCOrBranch=32'h0040_0024, in_WriteRegister=3 -> reg 31 = 32'h0040_0024; reg 3 unchanged.
- REQ-024: Write 32'hDEAD_BEEF to reg 0 -> reg 0 reads 0; out_WBValid=0; count unchanged.
- REQ-025: Write reg 9 with reset=1 in the same cycle -> reg 9 = 0; count = 0; after release, a write of memory data 32'hCAFE_0001 to reg 9 reads back 32'hCAFE_0001.
- REQ-026: Preload count 16'hFFFF via 65535 writes, then one more write -> out_WriteCount=0.
